reg_bank_param: RTL and testbench
=================================

// Module: reg_bank_param
// PURPOSE
//  Parametrised register bank for the EV22 datapath: GPRs, input/output port windows and the working register W.
//  Everything lives in one address space shared by two read ports (A, B) and one write port (C).
//  Reads are registered (1-cycle latency) with write-through bypass from port C and from the W load path.
//  Sits between the decoder's bus selects and the ALU; W is loaded from data memory through a separate port.
// PARAMETERS
//  DATA_W   16  data width of all registers and ports
//  NUM_GPR  28  number of general-purpose registers, addresses 0..NUM_GPR-1
//  NUM_IN   2   input ports, addresses NUM_GPR..NUM_GPR+NUM_IN-1 (read-only)
//  NUM_OUT  2   output ports, addresses following the inputs (read/write)
//  ADDR_W   6   width of all address selects
//  W_ADDR   34  address of W; required: NUM_GPR+NUM_IN+NUM_OUT <= W_ADDR < 2**ADDR_W
//  SYNC_IN  1   1 = two-flop synchroniser on every input port, 0 = direct
// PORTS
//  clk          in   1               clock, rising edge
//  reset        in   1               asynchronous, active-high
//  rd_en        in   1               capture a read on ports A and B this cycle
//  rd_a_addr    in   ADDR_W          port A select
//  rd_b_addr    in   ADDR_W          port B select
//  data_a       out  DATA_W          registered port A data
//  data_b       out  DATA_W          registered port B data
//  rd_valid     out  1               data_a/data_b hold a fresh read (rd_en delayed 1 cycle)
//  wr_en        in   1               port C write strobe
//  wr_addr      in   ADDR_W          port C select
//  wr_data      in   DATA_W          port C data
//  w_load       in   1               load W from memory
//  w_load_data  in   DATA_W          memory data for W
//  w_out        out  DATA_W          current W contents
//  in_port      in   NUM_IN*DATA_W   input ports; port k = bits [k*DATA_W +: DATA_W]
//  out_port     out  NUM_OUT*DATA_W  output port registers, same packing
//  out_wr_stb   out  NUM_OUT         1-cycle pulse when output port k is written
// BEHAVIOUR
//  Reset: all GPRs, W, out_port, data_a, data_b, rd_valid, out_wr_stb and the sync flops go to 0 immediately.
//   A read in flight at reset is discarded: rd_valid = 0 on the first edge after reset deasserts.
//  Reads: on a clk edge with rd_en=1, data_a/data_b <= value at the selected address; rd_valid <= rd_en.
//   With rd_en=0, data_a/data_b hold their values.
//   Both ports may read any address including W; unmapped addresses read 0.
//  Input reads: with SYNC_IN=1, an input port reads its value sampled 2 edges earlier; with SYNC_IN=0, its current value.
//  Write-through: if the read and the write target the same writable address on the same edge, data_x <= the new value.
//   For a GPR or output port the new value is wr_data.
//   For W_ADDR the new value is w_load_data if w_load=1, else wr_data if wr_en=1.
//  Writes (wr_en=1) take effect at the edge:
//   - GPR: register updated.
//   - Output port k: out_port[k] updated and out_wr_stb[k]=1 for exactly one cycle.
//   - Input-port and unmapped addresses: no effect.
//   - W_ADDR: W <= wr_data, unless w_load=1.
//  W load: w_load=1 -> W <= w_load_data; it has priority over a port C write to W_ADDR in the same cycle.
//   A port C write to any other address proceeds in parallel.
//  w_out is combinational from W, i.e. it updates in the cycle after the write edge.
//  No default/fallback write target: a wr_addr outside the map never disturbs W or any GPR.
//  Address compare uses the full ADDR_W bits; there is no aliasing or wrap-around of the address space.
// TESTING
//  1. Reset mid-run: write r5=0x1234, assert reset -> all outputs 0, r5 reads back 0, rd_valid=0.
//  2. Read latency: write r3=0xBEEF, then rd_en with A=3, B=3 -> data_a=data_b=0xBEEF one edge later, rd_valid=1.
//  3. Bypass: wr r7=0x00AA and read A=7 on the same edge -> data_a=0x00AA; read of addr 28 after writing 0x5555 -> unchanged, r0..r27 untouched.
//  4. W priority: w_load=1 (0x0F0F) and wr_en to W_ADDR (0x1111) together -> w_out=0x0F0F, B read of W_ADDR same edge=0x0F0F.
//  5. Output ports: wr addr 30=0xCAFE -> out_port[0]=0xCAFE, out_wr_stb=2'b01 for 1 cycle; wr addr 40 -> nothing changes.
//  6. Sync: in_port[1] 0->0x7777 -> A read of addr 29 returns 0x7777 no earlier than 2 edges after the change (SYNC_IN=1).

Source files
------------

// File: rtl/reg_bank_param.sv
// Register bank for the EV22 datapath: GPRs, input/output port windows and W,
// sharing one address space with two registered read ports and one write port.
module reg_bank_param #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 28,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int ADDR_W  = 6,
  parameter int W_ADDR  = 34,
  parameter int SYNC_IN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_a_addr,
  input  logic [ADDR_W-1:0]         rd_b_addr,
  output logic [DATA_W-1:0]         data_a,
  output logic [DATA_W-1:0]         data_b,
  output logic                      rd_valid,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      w_load,
  input  logic [DATA_W-1:0]         w_load_data,
  output logic [DATA_W-1:0]         w_out,
  input  logic [NUM_IN*DATA_W-1:0]  in_port,
  output logic [NUM_OUT*DATA_W-1:0] out_port,
  output logic [NUM_OUT-1:0]        out_wr_stb
);

  localparam int IN_BASE  = NUM_GPR;
  localparam int OUT_BASE = NUM_GPR + NUM_IN;

  logic [DATA_W-1:0]        gpr_q [NUM_GPR];
  logic [DATA_W-1:0]        gpr_d [NUM_GPR];
  logic [DATA_W-1:0]        out_q [NUM_OUT];
  logic [DATA_W-1:0]        out_d [NUM_OUT];
  logic [DATA_W-1:0]        w_q, w_d;
  logic [NUM_OUT-1:0]       stb_q, stb_d;
  logic [NUM_IN*DATA_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, in_view;
  logic [DATA_W-1:0]        data_a_q, data_a_d, data_b_q, data_b_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     first_q, first_d;
  logic [ADDR_W-1:0]        rd_addr [2];
  logic [DATA_W-1:0]        rd_val [2];

  // Next state of every writable register; a W load beats a port C write to W.
  always_comb begin
    gpr_d = gpr_q;
    out_d = out_q;
    stb_d = '0;
    w_d   = w_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (wr_addr == ADDR_W'(i)) gpr_d[i] = wr_data;
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (wr_addr == ADDR_W'(OUT_BASE + k)) begin
          out_d[k] = wr_data;
          stb_d[k] = 1'b1;
        end
      end
      if (wr_addr == ADDR_W'(W_ADDR)) w_d = wr_data;
    end
    if (w_load) w_d = w_load_data;
  end

  // Input synchroniser chain; the read path sees either its tail or the raw pins.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    in_view = (SYNC_IN != 0) ? sync2_q : in_port;
  end

  // Read muxes take the next-state values, which gives write-through for free.
  always_comb begin
    rd_addr[0] = rd_a_addr;
    rd_addr[1] = rd_b_addr;
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      for (int i = 0; i < NUM_GPR; i++) begin
        if (rd_addr[p] == ADDR_W'(i)) rd_val[p] = gpr_d[i];
      end
      for (int k = 0; k < NUM_IN; k++) begin
        if (rd_addr[p] == ADDR_W'(IN_BASE + k)) rd_val[p] = in_view[k*DATA_W +: DATA_W];
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (rd_addr[p] == ADDR_W'(OUT_BASE + k)) rd_val[p] = out_d[k];
      end
      if (rd_addr[p] == ADDR_W'(W_ADDR)) rd_val[p] = w_d;
    end
    first_d    = 1'b0;
    rd_valid_d = rd_en & ~first_q;
    data_a_d   = rd_valid_d ? rd_val[0] : data_a_q;
    data_b_d   = rd_valid_d ? rd_val[1] : data_b_q;
  end

  // State registers; first_q drops any read captured on the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
      w_q        <= '0;
      stb_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      rd_valid_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      gpr_q      <= gpr_d;
      out_q      <= out_d;
      w_q        <= w_d;
      stb_q      <= stb_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      rd_valid_q <= rd_valid_d;
      first_q    <= first_d;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_port[k*DATA_W +: DATA_W] = out_q[k];
  end

  assign data_a     = data_a_q;
  assign data_b     = data_b_q;
  assign rd_valid   = rd_valid_q;
  assign w_out      = w_q;
  assign out_wr_stb = stb_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: directed scenarios then random traffic
// compared against an array-based model of the register map.
module tb_reg_bank_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [5:0]  rd_a_addr, rd_b_addr;
  logic [15:0] data_a, data_b;
  logic        rd_valid;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        w_load;
  logic [15:0] w_load_data;
  logic [15:0] w_out;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic [1:0]  out_wr_stb;

  int tests = 0;
  int failures = 0;

  // Model of the map: 28 GPRs, 2 inputs (28,29), 2 outputs (30,31), W at 34.
  logic [15:0] m_gpr [28];
  logic [15:0] m_out [2];
  logic [15:0] m_w;
  logic [31:0] m_in1, m_in2;
  logic [15:0] m_a, m_b;
  logic        m_valid;
  logic [1:0]  m_stb;
  logic        m_first;

  reg_bank_param dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .data_a(data_a), .data_b(data_b), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .w_load(w_load), .w_load_data(w_load_data), .w_out(w_out),
    .in_port(in_port), .out_port(out_port), .out_wr_stb(out_wr_stb)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [5:0] addr);
    int a = int'(addr);
    if (a < 28) return m_gpr[a];
    if (a < 30) return m_in2[(a-28)*16 +: 16];
    if (a < 32) return m_out[a-30];
    if (a == 34) return m_w;
    return 16'h0000;
  endfunction

  task automatic setIdle();
    rd_en = 1'b0; wr_en = 1'b0; w_load = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0; wr_addr = '0; wr_data = '0; w_load_data = '0;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 28; i++) m_gpr[i] = '0;
    m_out[0] = '0; m_out[1] = '0; m_w = '0;
    m_in1 = '0; m_in2 = '0; m_a = '0; m_b = '0;
    m_valid = 1'b0; m_stb = '0; m_first = 1'b1;
  endtask

  // One clock: advance the model with the current inputs, then compare all outputs.
  task automatic applyStimulus();
    int a;
    m_stb = '0;
    if (wr_en) begin
      a = int'(wr_addr);
      if (a < 28) m_gpr[a] = wr_data;
      else if (a == 30 || a == 31) begin
        m_out[a-30] = wr_data;
        m_stb[a-30] = 1'b1;
      end else if (a == 34 && !w_load) m_w = wr_data;
    end
    if (w_load) m_w = w_load_data;
    m_valid = rd_en && !m_first;
    if (m_valid) begin
      m_a = modelRead(rd_a_addr);
      m_b = modelRead(rd_b_addr);
    end
    m_first = 1'b0;
    m_in2 = m_in1;
    m_in1 = in_port;
    @(posedge clk);
    #1;
    checkOutput("data_a", 32'(data_a), 32'(m_a));
    checkOutput("data_b", 32'(data_b), 32'(m_b));
    checkOutput("rd_valid", 32'(rd_valid), 32'(m_valid));
    checkOutput("w_out", 32'(w_out), 32'(m_w));
    checkOutput("out_port", out_port, {m_out[1], m_out[0]});
    checkOutput("out_wr_stb", 32'(out_wr_stb), 32'(m_stb));
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic resetMidRun();
    setIdle();
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_data_a", 32'(data_a), 32'h0);
    checkOutput("rst_data_b", 32'(data_b), 32'h0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("rst_w_out", 32'(w_out), 32'h0);
    checkOutput("rst_out_port", out_port, 32'h0);
    checkOutput("rst_out_wr_stb", 32'(out_wr_stb), 32'h0);
    clearModel();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_port = '0;
    setIdle();
    clearModel();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-run clears r5; a read on the first edge after reset is dropped.
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'h1234;
    applyStimulus();
    setIdle(); rd_en = 1'b1; rd_a_addr = 6'd5;
    applyStimulus();
    checkOutput("t1_r5_before", 32'(data_a), 32'h1234);
    resetMidRun();
    rd_en = 1'b1; rd_a_addr = 6'd5; rd_b_addr = 6'd5;
    applyStimulus();
    checkOutput("t1_first_valid", 32'(rd_valid), 32'h0);
    applyStimulus();
    checkOutput("t1_r5_after", 32'(data_a), 32'h0);
    checkOutput("t1_valid", 32'(rd_valid), 32'h1);

    // Read latency.
    setIdle(); wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'hBEEF;
    applyStimulus();
    setIdle(); rd_en = 1'b1; rd_a_addr = 6'd3; rd_b_addr = 6'd3;
    applyStimulus();
    checkOutput("t2_a", 32'(data_a), 32'hBEEF);
    checkOutput("t2_b", 32'(data_b), 32'hBEEF);

    // Write-through on a GPR; a write to an input address is ignored.
    setIdle(); wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'h00AA; rd_en = 1'b1; rd_a_addr = 6'd7;
    applyStimulus();
    checkOutput("t3_bypass", 32'(data_a), 32'h00AA);
    setIdle(); wr_en = 1'b1; wr_addr = 6'd28; wr_data = 16'h5555; rd_en = 1'b1; rd_a_addr = 6'd28;
    applyStimulus();
    checkOutput("t3_in_ro", 32'(data_a), 32'h0);

    // W load beats a port C write to W, including on the bypass path.
    setIdle(); w_load = 1'b1; w_load_data = 16'h0F0F; wr_en = 1'b1; wr_addr = 6'd34; wr_data = 16'h1111;
    rd_en = 1'b1; rd_b_addr = 6'd34;
    applyStimulus();
    checkOutput("t4_w", 32'(w_out), 32'h0F0F);
    checkOutput("t4_b", 32'(data_b), 32'h0F0F);

    // Output port write pulses the strobe once; an unmapped write does nothing.
    setIdle(); wr_en = 1'b1; wr_addr = 6'd30; wr_data = 16'hCAFE;
    applyStimulus();
    checkOutput("t5_out", out_port, 32'h0000CAFE);
    checkOutput("t5_stb", 32'(out_wr_stb), 32'h1);
    setIdle(); wr_en = 1'b1; wr_addr = 6'd40; wr_data = 16'hDEAD;
    applyStimulus();
    checkOutput("t5_stb_off", 32'(out_wr_stb), 32'h0);
    checkOutput("t5_w_keep", 32'(w_out), 32'h0F0F);

    // Synchronised input appears on the third read edge after the change.
    setIdle(); rd_en = 1'b1; rd_a_addr = 6'd29; in_port[31:16] = 16'h7777;
    applyStimulus();
    checkOutput("t6_edge1", 32'(data_a), 32'h0);
    applyStimulus();
    checkOutput("t6_edge2", 32'(data_a), 32'h0);
    applyStimulus();
    checkOutput("t6_edge3", 32'(data_a), 32'h7777);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rd_en = ($urandom_range(0, 3) != 0);
      rd_a_addr = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(0, 35)) : 6'($urandom_range(0, 63));
      rd_b_addr = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(0, 35)) : 6'($urandom_range(0, 63));
      wr_en = ($urandom_range(0, 1) != 0);
      wr_addr = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(0, 35)) : 6'($urandom_range(0, 63));
      wr_data = 16'($urandom);
      w_load = ($urandom_range(0, 4) == 0);
      w_load_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) in_port = $urandom;
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
